// File: rtl/blur_pkg.sv
// blur_pkg: state encoding, binomial coefficients and normalisation shift shared by the blur engine.
package blur_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, HPASS, VPASS, OUT} state_t;
  localparam int unsigned COEF3 [3] = '{1, 2, 1};
  localparam int unsigned COEF5 [5] = '{1, 4, 6, 4, 1};
  function automatic int unsigned coef(input int k, input int t);
    return (k == 3) ? COEF3[t % 3] : COEF5[t % 5];
  endfunction
  function automatic int unsigned shift_of(input int k);
    return (k == 3) ? 2 : 4;
  endfunction
endpackage

// File: rtl/blur_kernel.sv
// blur_kernel: one KERNEL-tap binomial dot product with round-half-up normalisation.
module blur_kernel import blur_pkg::*; #(
  parameter int PIX_BITS = 8,
  parameter int KERNEL   = 5
) (
  input  logic [KERNEL*PIX_BITS-1:0] taps_i,
  output logic [PIX_BITS-1:0]        pix_o
);
  localparam int SW = PIX_BITS + 4;
  localparam int S  = shift_of(KERNEL);
  logic [SW-1:0] acc;
  always_comb begin
    acc = SW'(1 << (S - 1));
    for (int t = 0; t < KERNEL; t++) acc = acc + SW'(coef(KERNEL, t)) * SW'(taps_i[t*PIX_BITS +: PIX_BITS]);
  end
  assign pix_o = PIX_BITS'(acc >> S);
endmodule

// File: rtl/flex_counter.sv
// flex_counter: index counter counting 0..rollover_val_i with synchronous clear and a last-index flag.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear_i,
  input  logic                    count_enable_i,
  input  logic [NUM_CNT_BITS-1:0] rollover_val_i,
  output logic [NUM_CNT_BITS-1:0] count_o,
  output logic                    rollover_flag_o
);
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  assign rollover_flag_o = count_q == rollover_val_i;
  assign count_o = count_q;
  always_comb count_d = clear_i ? '0 : !count_enable_i ? count_q : rollover_flag_o ? '0 : count_q + 1'b1;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/sep_blur_engine.sv
// sep_blur_engine: separable binomial blur; horizontal pass into a KERNEL-row circular history, vertical pass to one output row.
// BLUR_EDGE_REPLICATE_EN: vertical pass runs from the first row, replicating the oldest valid row into missing slots.
module sep_blur_engine import blur_pkg::*; #(
  parameter int PIX_BITS = 8,
  parameter int TILE_W   = 16,
  parameter int KERNEL   = 5
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic                                   frame_start,
  input  logic                                   strip_valid,
  output logic                                   strip_ready,
  input  logic [PIX_BITS*(TILE_W+KERNEL-1)-1:0]  strip_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [PIX_BITS*TILE_W-1:0]             out_row,
  output logic                                   rows_primed,
  output logic                                   busy
);
  localparam int NW  = TILE_W + KERNEL - 1;
  localparam int CW  = $clog2(TILE_W);
  localparam int PW  = $clog2(KERNEL);
  localparam int HW  = $clog2(KERNEL + 1);
  localparam int NIW = $clog2(NW);
`ifdef BLUR_EDGE_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif
  state_t                state_q, state_d;
  logic                  rdy_q, rdy_d, ov_q, ov_d;
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [HW-1:0]         hcnt_q, hcnt_d, hcnt_inc;
  logic [PIX_BITS-1:0]   strip_q [NW];
  logic [PIX_BITS-1:0]   hist_q [KERNEL][TILE_W];
  logic [PIX_BITS-1:0]   out_row_q [TILE_W];
  logic [CW-1:0]         idx;
  logic                  last, cnt_clr, cnt_en, accept;
  logic [KERNEL*PIX_BITS-1:0] taps;
  logic [PIX_BITS-1:0]   kout;

  flex_counter #(.NUM_CNT_BITS(CW)) u_idx (
    .clk(clk), .n_rst(n_rst), .clear_i(cnt_clr), .count_enable_i(cnt_en),
    .rollover_val_i(CW'(TILE_W - 1)), .count_o(idx), .rollover_flag_o(last)
  );
  blur_kernel #(.PIX_BITS(PIX_BITS), .KERNEL(KERNEL)) u_kernel (.taps_i(taps), .pix_o(kout));

  assign accept   = strip_valid & rdy_q;
  assign hcnt_inc = (hcnt_q == HW'(KERNEL)) ? hcnt_q : hcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE:  state_d = accept ? LOAD : IDLE;
      LOAD:  begin state_d = HPASS; cnt_clr = 1'b1; end
      HPASS: begin
        cnt_en  = 1'b1;
        cnt_clr = last;
        if (last) state_d = (REPL || hcnt_inc == HW'(KERNEL)) ? VPASS : IDLE;
      end
      VPASS: begin cnt_en = 1'b1; if (last) state_d = OUT; end
      OUT:   state_d = (ov_q && out_ready) ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    hcnt_d = hcnt_q;
    if (rdy_q && frame_start) begin
      wptr_d = '0;
      hcnt_d = '0;
    end
    if (state_q == HPASS && last) begin
      wptr_d = (wptr_q == PW'(KERNEL - 1)) ? '0 : wptr_q + 1'b1;
      hcnt_d = hcnt_inc;
    end
  end

  assign rdy_d = state_d == IDLE;
  assign ov_d  = (state_q == OUT) && !(ov_q && out_ready);

  // Tap t reads history age KERNEL-1-t (0 = newest); replication clamps the age to the oldest valid row.
  function automatic logic [PW-1:0] slot_of(input int t, input int w, input int c);
    int age, s;
    age = KERNEL - 1 - t;
    if (REPL && age > c - 1) age = c - 1;
    s = w + KERNEL - 1 - age;
    return PW'((s >= KERNEL) ? s - KERNEL : s);
  endfunction

  always_comb begin
    taps = '0;
    for (int t = 0; t < KERNEL; t++)
      taps[t*PIX_BITS +: PIX_BITS] = (state_q == VPASS) ? hist_q[slot_of(t, int'(wptr_q), int'(hcnt_q))][idx]
                                                        : strip_q[NIW'(int'(idx) + t)];
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q   <= IDLE;
      rdy_q     <= 1'b0;
      ov_q      <= 1'b0;
      wptr_q    <= '0;
      hcnt_q    <= '0;
      out_row_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      ov_q    <= ov_d;
      wptr_q  <= wptr_d;
      hcnt_q  <= hcnt_d;
      if (state_q == VPASS) out_row_q[idx] <= kout;
    end

  always_ff @(posedge clk) begin
    if (state_q == LOAD)
      for (int j = 0; j < NW; j++) strip_q[j] <= strip_in[j*PIX_BITS +: PIX_BITS];
    if (state_q == HPASS) hist_q[wptr_q][idx] <= kout;
  end

  for (genvar g = 0; g < TILE_W; g++) begin : g_out
    assign out_row[g*PIX_BITS +: PIX_BITS] = out_row_q[g];
  end

  assign strip_ready = rdy_q;
  assign out_valid   = ov_q;
  assign rows_primed = hcnt_q >= HW'(KERNEL - 1);
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_sep_blur_engine.sv
// tb_sep_blur_engine: scoreboard bench for sep_blur_engine (defaults plus a KERNEL=3, TILE_W=4 instance).
module tb_sep_blur_engine;
  localparam int P = 8, W = 16, K = 5, NW = W + K - 1;
`ifdef BLUR_EDGE_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif
  logic clk = 0, n_rst = 0, frame_start = 0, strip_valid = 0, out_ready = 1;
  logic [P*NW-1:0] strip_in = '0;
  logic strip_ready, out_valid, rows_primed, busy;
  logic [P*W-1:0] out_row;
  logic frame_start3 = 0, strip_valid3 = 0, out_ready3 = 1;
  logic [47:0] strip_in3 = '0;
  logic strip_ready3, out_valid3, rows_primed3, busy3;
  logic [31:0] out_row3;

  sep_blur_engine #(.PIX_BITS(P), .TILE_W(W), .KERNEL(K)) dut (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start), .strip_valid(strip_valid),
    .strip_ready(strip_ready), .strip_in(strip_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .rows_primed(rows_primed), .busy(busy));
  sep_blur_engine #(.PIX_BITS(8), .TILE_W(4), .KERNEL(3)) u3 (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start3), .strip_valid(strip_valid3),
    .strip_ready(strip_ready3), .strip_in(strip_in3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_row(out_row3), .rows_primed(rows_primed3), .busy(busy3));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [P*W-1:0] row; int acc;} exp_t;
  exp_t sb[$];
  exp_t e_mon;
  bit prev_ov = 0, ov3_prev = 0;
  int ov3_rises = 0;
  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [P*W-1:0] got, input logic [P*W-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic checki(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic logic [P*NW-1:0] flat_in(input logic [7:0] v);
    return {NW{v}};
  endfunction
  function automatic logic [P*W-1:0] flat_out(input logic [7:0] v);
    return {W{v}};
  endfunction

  task automatic send(input logic [P*NW-1:0] pix, input bit fs, input bit want_out, input logic [P*W-1:0] want);
    int n = 0;
    @(negedge clk);
    strip_in = pix; strip_valid = 1; frame_start = fs;
    while (!strip_ready && n < 300) begin @(negedge clk); n++; end
    if (!strip_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: strip_ready=%b expected 1", strip_ready);
    end else if (want_out) sb.push_back('{row: want, acc: cyc + 1});
    @(negedge clk);
    strip_valid = 0; frame_start = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while ((!strip_ready || sb.size() != 0) && n < 300) begin @(negedge clk); n++; end
    if (!strip_ready || sb.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: strip_ready=%b pending=%0d expected 1/0", strip_ready, sb.size());
    end
  endtask

  // Monitor: every rising out_valid must match the oldest expectation, 34 cycles after its accept edge.
  initial forever begin
    @(negedge clk);
    if (!n_rst) prev_ov = 0;
    else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_output: out_valid=1 expected 0 (row %h)", out_row);
        end else begin
          e_mon = sb.pop_front();
          check("out_row", out_row, e_mon.row);
          checki("latency", cyc - e_mon.acc, 2 + 2 * W);
        end
      end
      prev_ov = out_valid;
    end
  end

  always @(negedge clk) begin
    ov3_prev <= out_valid3;
    if (out_valid3 && !ov3_prev) ov3_rises <= ov3_rises + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [P*NW-1:0] imp;
    logic [P*W-1:0] imp_out, want;
    logic [47:0] s3;
    int n, acc3, stable;
    repeat (3) @(negedge clk);
    checki("rst_strip_ready", strip_ready, 0);
    checki("rst_out_valid", out_valid, 0);
    check("rst_out_row", out_row, '0);
    checki("rst_rows_primed", rows_primed, 0);
    checki("rst_busy", busy, 0);
    n_rst = 1;
    @(negedge clk);
    checki("ready_after_reset", strip_ready, 1);

    for (int r = 1; r <= 5; r++) begin
      send(flat_in(100), r == 1, REPL || r == 5, flat_out(100));
      if (r == 3 || r == 4) begin
        wait_ready();
        checki("rows_primed", rows_primed, int'(r == 4));
      end
    end
    wait_ready();

`ifndef BLUR_EDGE_REPLICATE_EN
    imp = '0; imp[7*P +: P] = 8'd160;
    imp_out = '0;
    imp_out[3*P +: P] = 8'd4; imp_out[4*P +: P] = 8'd15; imp_out[5*P +: P] = 8'd23;
    imp_out[6*P +: P] = 8'd15; imp_out[7*P +: P] = 8'd4;
    send('0, 1, 0, '0);
    send('0, 0, 0, '0);
    send(imp, 0, 0, '0);
    send('0, 0, 0, '0);
    send('0, 0, 1, imp_out);
    wait_ready();
`endif

    for (int r = 1; r <= 4; r++) send(flat_in(77), r == 1, REPL, flat_out(77));
    wait_ready();
    out_ready = 0;
    send(flat_in(77), 0, 1, flat_out(77));
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    checki("bp_out_valid", out_valid, 1);
    stable = 1;
    repeat (40) begin
      @(negedge clk);
      if (out_row !== flat_out(77) || strip_ready !== 1'b0 || out_valid !== 1'b1) stable = 0;
    end
    checki("bp_hold_stable", stable, 1);
    out_ready = 1;
    @(negedge clk);
    checki("bp_release_ready", strip_ready, 1);
    checki("bp_release_valid", out_valid, 0);
    wait_ready();

    send(flat_in(50), 1, 0, '0);
    repeat (8) @(negedge clk);
    checki("busy_in_hpass", busy, 1);
    n_rst = 0;
    #1;
    checki("mid_rst_strip_ready", strip_ready, 0);
    checki("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_row", out_row, '0);
    checki("mid_rst_rows_primed", rows_primed, 0);
    checki("mid_rst_busy", busy, 0);
    @(negedge clk);
    n_rst = 1;
    for (int r = 1; r <= 5; r++) send(flat_in(50), 0, REPL || r == 5, flat_out(50));
    wait_ready();

    send(flat_in(200), 1, REPL, flat_out(200));
    wait_ready();
    checki("single_row_primed", rows_primed, 0);

    for (int r = 0; r < 3; r++) begin
      for (int j = 0; j < 6; j++) s3[j*8 +: 8] = 8'(40 * ((j + r) % 3));
      @(negedge clk);
      strip_in3 = s3; strip_valid3 = 1; frame_start3 = (r == 0);
      n = 0;
      while (!strip_ready3 && n < 100) begin @(negedge clk); n++; end
      if (!strip_ready3) begin
        vectors++; miscompares++;
        $display("FAIL k3_accept_timeout: strip_ready=%b expected 1", strip_ready3);
      end
      acc3 = cyc + 1;
      @(negedge clk);
      strip_valid3 = 0; frame_start3 = 0;
      if (r == 2) out_ready3 = 0;
    end
    n = 0;
    while (!out_valid3 && n < 100) begin @(negedge clk); n++; end
    checki("k3_latency", cyc - acc3, 10);
    want = '0;
    want[31:0] = {8'd43, 8'd40, 8'd38, 8'd43};
    check("k3_out_row", {96'b0, out_row3}, want);
    out_ready3 = 1;
    repeat (2) @(negedge clk);
    checki("k3_output_count", ov3_rises, REPL ? 3 : 1);
    checki("k3_ready_after", strip_ready3, 1);

    checki("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
